io_timer: RTL and testbench

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_pkg.sv | 27 ++
 rtl/io_prescaler.sv | 32 +++
 rtl/io_timer.sv | 149 ++++++++++++++
 tb/tb_io_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the io_timer register window.
//   - register index constants (word index = io_addr[4:2])
//   - packed CTRL bitfield struct and a helper that widens it to a bus word
package io_pkg;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_COUNT  = 3'd1;
  localparam logic [2:0] IDX_RELOAD = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_CYCLE  = 3'd4;

  // CTRL layout, low 16 bits of the register word:
  //   [15:8] presc, [7:3] reserved (always 0), [2] ie, [1] auto_reload, [0] en
  typedef struct packed {
    logic [7:0] presc;
    logic [4:0] rsvd;
    logic       ie;
    logic       auto_reload;
    logic       en;
  } ctrl_t;

  // Zero-extend CTRL to the 32-bit read bus.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {16'h0000, c};
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// io_prescaler: 8-bit prescaler for io_timer.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (prescaler holds while low)
//   presc    : terminal value; tick fires when the counter equals it
//   clr      : synchronous clear (has priority over counting)
//   tick     : one-cycle pulse, a function of registered state only
module io_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] cnt;

  // presc == 0 makes the counter sit at 0 and tick every enabled cycle.
  assign tick = en && (cnt == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      if (tick) cnt <= 8'd0;
      else      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer with prescaler, auto-reload,
// sticky pending flag, interrupt and a free-running cycle counter.
//   clk, rst  : clock, asynchronous active-high reset
//   io_r      : read strobe
//   io_w      : write strobe
//   io_addr   : byte address (window of 32 bytes at BASE_ADDR)
//   io_wdata  : write data
//   io_rdata  : read data (combinational, zero wait states)
//   irq       : interrupt request = PEND & IE
// Register map (word index io_addr[4:2]):
//   0 CTRL   [0] EN, [1] AUTO, [2] IE, [15:8] PRESC
//   1 COUNT  current count
//   2 RELOAD reload value for auto mode
//   3 STATUS [0] PEND, write 1 to clear
//   4 CYCLE  free-running cycle counter, read-only
//
// Bus handshake: there is no ready/valid pair; every access completes in the
// cycle its strobe is high. A read returns data combinationally in that cycle;
// a write commits on the rising edge that ends it. With both strobes high the
// read returns the value held before the write.
module io_timer
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        irq
);

  ctrl_t       ctrl;
  logic [31:0] count;
  logic [31:0] reload;
  logic        pend;
  logic [31:0] cycle;

  logic        sel;
  logic [2:0]  idx;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_reload;
  logic        wr_status;
  logic        tick;
  logic        expire;

  // Byte lanes within a word are not decoded.
  logic        unused_addr;
  assign unused_addr = ^io_addr[1:0];

  assign sel       = (io_addr[15:5] == BASE_ADDR[15:5]);
  assign idx       = io_addr[4:2];
  assign wr        = io_w && sel;
  assign wr_ctrl   = wr && (idx == IDX_CTRL);
  assign wr_count  = wr && (idx == IDX_COUNT);
  assign wr_reload = wr && (idx == IDX_RELOAD);
  assign wr_status = wr && (idx == IDX_STATUS);

  // A CTRL write restarts the prescale period so the first timer tick after
  // enabling lands exactly PRESC+1 cycles later.
  io_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.en),
    .presc (ctrl.presc),
    .clr   (wr_ctrl),
    .tick  (tick)
  );

  // Expiry is a tick that finds COUNT already at zero, which is what makes
  // the period (RELOAD+1)*(PRESC+1).
  assign expire = tick && (count == 32'd0);

  // CTRL: a software write wins over the one-shot EN clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.presc       <= io_wdata[15:8];
      ctrl.rsvd        <= 5'd0;
      ctrl.ie          <= io_wdata[2];
      ctrl.auto_reload <= io_wdata[1];
      ctrl.en          <= io_wdata[0];
    end else if (expire && !ctrl.auto_reload) begin
      ctrl.en <= 1'b0;
    end
  end

  // COUNT: a software write wins over the tick update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= io_wdata;
    end else if (tick) begin
      if (count != 32'd0)        count <= count - 32'd1;
      else if (ctrl.auto_reload) count <= reload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= 32'd0;
    end else if (wr_reload) begin
      reload <= io_wdata;
    end
  end

  // PEND: a same-cycle expiry wins over write-1-to-clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (expire) begin
      pend <= 1'b1;
    end else if (wr_status && io_wdata[0]) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= 32'd0;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  assign irq = pend && ctrl.ie;

  always_comb begin
    io_rdata = 32'd0;
    if (io_r && sel) begin
      case (idx)
        IDX_CTRL:   io_rdata = ctrl_to_word(ctrl);
        IDX_COUNT:  io_rdata = count;
        IDX_RELOAD: io_rdata = reload;
        IDX_STATUS: io_rdata = {31'd0, pend};
        IDX_CYCLE:  io_rdata = cycle;
        default:    io_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] A_CTRL   = BASE + 16'h0;
  localparam logic [15:0] A_COUNT  = BASE + 16'h4;
  localparam logic [15:0] A_RELOAD = BASE + 16'h8;
  localparam logic [15:0] A_STATUS = BASE + 16'hC;
  localparam logic [15:0] A_CYCLE  = BASE + 16'h10;

  logic        clk;
  logic        rst;
  logic        io_r;
  logic        io_w;
  logic [15:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        irq;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_r     (io_r),
    .io_w     (io_w),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .irq      (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle. Called at posedge+1, returns at the next posedge+1 with
  // strobes low. Expected read data goes through the scoreboard queue.
  task automatic access(input logic r, input logic w, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp,
                        input string name);
    logic [31:0] e;
    exp_q.push_back(exp);
    io_r = r;
    io_w = w;
    io_addr = addr;
    io_wdata = wdata;
    #3;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, io_rdata, e);
    end
    @(posedge clk);
    #1;
    io_r = 1'b0;
    io_w = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] d, input string name);
    access(1'b0, 1'b1, addr, d, 32'd0, name);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    access(1'b1, 1'b0, addr, 32'd0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] rnd;
    logic [31:0] c1;
    logic [31:0] c2;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    io_r = 1'b0;
    io_w = 1'b0;
    io_addr = 16'h0;
    io_wdata = 32'h0;

    rnd = $urandom_range(32'h7FFF_FFFF, 1);
    tbl[0]  = '{1'b1, 1'b0, A_CTRL,          32'h0,         32'h0};
    tbl[1]  = '{1'b1, 1'b0, A_COUNT,         32'h0,         32'h0};
    tbl[2]  = '{1'b1, 1'b0, A_RELOAD,        32'h0,         32'h0};
    tbl[3]  = '{1'b1, 1'b0, A_STATUS,        32'h0,         32'h0};
    tbl[4]  = '{1'b0, 1'b1, A_RELOAD,        32'hDEADBEEF,  32'h0};
    tbl[5]  = '{1'b1, 1'b0, A_RELOAD + 16'h2, 32'h0,        32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, A_CTRL,          32'hABCD_FF06, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, A_CTRL + 16'h3,  32'h0,         32'h0000_FF06};
    tbl[8]  = '{1'b0, 1'b1, A_CTRL,          32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b0, A_CTRL,          32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b1, A_COUNT,         rnd,           32'h0};
    tbl[11] = '{1'b1, 1'b0, A_COUNT,         32'h0,         rnd};
    tbl[12] = '{1'b0, 1'b0, A_RELOAD,        32'h0,         32'h0};
    tbl[13] = '{1'b1, 1'b0, A_STATUS,        32'h0,         32'h0};

    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    io_r = 1'b1;
    io_addr = A_CYCLE;
    #2;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata_cycle", io_rdata, 32'd0);
    io_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      access(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].exp, "tbl");
    end
    check("idle_irq", {31'd0, irq}, 32'd0);

    // CYCLE: nonzero and advancing by one per cycle
    io_r = 1'b1;
    io_addr = A_CYCLE;
    #3;
    c1 = io_rdata;
    @(posedge clk);
    #4;
    c2 = io_rdata;
    io_r = 1'b0;
    check("cycle_nonzero", {31'd0, (c1 != 32'd0)}, 32'd1);
    check("cycle_step", c2 - c1, 32'd1);
    @(posedge clk);
    #1;

    // auto-reload, PRESC=0, period 4
    wr(A_RELOAD, 32'd3, "w_reload");
    wr(A_COUNT, 32'd3, "w_count");
    wr(A_CTRL, 32'h0000_0007, "w_ctrl_auto");
    idle(3);
    check("auto_irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    check("auto_irq_first", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'd1, "w_clr1");
    check("auto_irq_cleared", {31'd0, irq}, 32'd0);
    idle(2);
    check("auto_irq_gap", {31'd0, irq}, 32'd0);
    idle(1);
    check("auto_irq_second", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'd0, "w_ctrl_off");
    wr(A_STATUS, 32'd1, "w_clr2");
    check("auto_irq_off", {31'd0, irq}, 32'd0);

    // one-shot, PRESC=1
    wr(A_COUNT, 32'd2, "w_count2");
    wr(A_CTRL, 32'h0000_0105, "w_ctrl_oneshot");
    idle(5);
    check("one_irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    check("one_irq_set", {31'd0, irq}, 32'd1);
    rd(A_CTRL, 32'h0000_0104, "one_en_cleared");
    rd(A_COUNT, 32'd0, "one_count_zero");
    wr(A_STATUS, 32'd1, "w_clr3");
    idle(10);
    rd(A_STATUS, 32'd0, "one_no_repend");
    rd(A_COUNT, 32'd0, "one_count_hold");

    // clear coincident with expiry: set wins
    wr(A_COUNT, 32'd1, "w_count1");
    wr(A_CTRL, 32'h0000_0005, "w_ctrl_race");
    idle(1);
    wr(A_STATUS, 32'd1, "w_clr_race");
    rd(A_STATUS, 32'd1, "race_pend_kept");
    wr(A_STATUS, 32'd1, "w_clr4");

    // read+write same cycle returns pre-write value
    wr(A_COUNT, 32'd5, "w_count5");
    access(1'b1, 1'b1, A_COUNT, 32'h10, 32'd5, "rw_prewrite");
    rd(A_COUNT, 32'h10, "rw_postwrite");

    // out-of-window and unmapped accesses
    access(1'b1, 1'b1, 16'h0200, 32'hFFFF_FFFF, 32'd0, "oow_rdata");
    access(1'b1, 1'b1, BASE + 16'h18, 32'hFFFF_FFFF, 32'd0, "idx6_rdata");
    rd(BASE + 16'h1C, 32'd0, "idx7_rdata");
    rd(A_CTRL, 32'h0000_0004, "oow_ctrl_kept");
    rd(A_COUNT, 32'h10, "oow_count_kept");
    rd(A_RELOAD, 32'd3, "oow_reload_kept");

    // reset mid-countdown
    wr(A_RELOAD, 32'd7, "w_reload7");
    wr(A_COUNT, 32'd7, "w_count7");
    wr(A_CTRL, 32'h0000_0307, "w_ctrl_run");
    idle(5);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      io_r = 1'b1;
      io_addr = BASE + 16'(i * 4);
      #1;
      check("mid_rst_rdata", io_rdata, 32'd0);
    end
    io_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    rd(A_CTRL, 32'd0, "post_rst_ctrl");
    rd(A_COUNT, 32'd0, "post_rst_count");
    rd(A_RELOAD, 32'd0, "post_rst_reload");
    rd(A_STATUS, 32'd0, "post_rst_status");
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
